// File: rtl/alu_op_driver.sv
// alu_op_driver: decodes one instruction, drives the ALU for SETTLE_CYCLES
// cycles, captures the outcome and hands it off over a valid/ready pair.
module alu_op_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm,
  input  logic [31:0] pc_plus4,
  output logic [3:0]  alu_operation,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        branch_taken,
  output logic        unsupported
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_NOR  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_LUI  = 4'd5,
    OP_JAL  = 4'd6,
    OP_NONE = 4'd7
  } alu_op_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  alu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [5:0]  opc_q, opc_d;
  logic        pend_unsup_q, pend_unsup_d;
  logic [31:0] result_q, result_d;
  logic        taken_q, taken_d;
  logic        unsup_q, unsup_d;

  alu_op_e     dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_unsup;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  always_comb begin
    dec_op    = OP_NONE;
    dec_a     = '0;
    dec_b     = '0;
    dec_unsup = 1'b1;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin dec_op = OP_ADD; dec_unsup = 1'b0; end
          6'h22, 6'h23: begin dec_op = OP_SUB; dec_unsup = 1'b0; end
          6'h24:        begin dec_op = OP_AND; dec_unsup = 1'b0; end
          6'h25:        begin dec_op = OP_OR;  dec_unsup = 1'b0; end
          6'h27:        begin dec_op = OP_NOR; dec_unsup = 1'b0; end
          default:      dec_unsup = 1'b1;
        endcase
        if (!dec_unsup) begin
          dec_a = rs_data;
          dec_b = rt_data;
        end
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin
        dec_op = OP_ADD; dec_a = rs_data; dec_b = imm_sext; dec_unsup = 1'b0;
      end
      6'h0C: begin
        dec_op = OP_AND; dec_a = rs_data; dec_b = imm_zext; dec_unsup = 1'b0;
      end
      6'h0D: begin
        dec_op = OP_OR;  dec_a = rs_data; dec_b = imm_zext; dec_unsup = 1'b0;
      end
      6'h0F: begin
        dec_op = OP_LUI; dec_a = rs_data; dec_b = imm_zext; dec_unsup = 1'b0;
      end
      6'h04, 6'h05: begin
        dec_op = OP_SUB; dec_a = rs_data; dec_b = rt_data;  dec_unsup = 1'b0;
      end
      6'h03: begin
        dec_op = OP_JAL; dec_a = rs_data; dec_b = pc_plus4; dec_unsup = 1'b0;
      end
      default: dec_unsup = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    opc_d        = opc_q;
    pend_unsup_d = pend_unsup_q;
    result_d     = result_q;
    taken_d      = taken_q;
    unsup_d      = unsup_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d         = dec_op;
          a_d          = dec_a;
          b_d          = dec_b;
          opc_d        = opcode;
          pend_unsup_d = dec_unsup;
          cnt_d        = SETTLE_INIT;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          result_d = pend_unsup_q ? '0 : alu_result;
          if (pend_unsup_q)         taken_d = 1'b0;
          else if (opc_q == 6'h04)  taken_d = alu_zero;
          else if (opc_q == 6'h05)  taken_d = ~alu_zero;
          else                      taken_d = 1'b0;
          unsup_d  = pend_unsup_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      opc_q        <= '0;
      pend_unsup_q <= 1'b0;
      result_q     <= '0;
      taken_q      <= 1'b0;
      unsup_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      opc_q        <= opc_d;
      pend_unsup_q <= pend_unsup_d;
      result_q     <= result_d;
      taken_q      <= taken_d;
      unsup_q      <= unsup_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign alu_operation = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign result        = result_q;
  assign branch_taken  = taken_q;
  assign unsupported   = unsup_q;

endmodule
